// File: rtl/spi_transfer_ctrl.sv
// SPI master transfer controller: 8/16/32-bit MSB-first transfers, CPHA=0, selectable CPOL,
// programmable SCLK half-period divider and optional chip-select hold between transfers.
module spi_transfer_ctrl #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] spi_bitrate,
  input  logic [31:0] spi_data_out,
  input  logic [7:0]  spi_ctrl,
  input  logic        ctrl_wr,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic [31:0] spi_data_in,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  localparam logic [DIV_WIDTH-1:0] DivOne = DIV_WIDTH'(1);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [5:0]           half_q, half_d;
  logic [1:0]           len_q, len_d;
  logic                 cpol_q, cpol_d;
  logic                 hold_q, hold_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 done_q, done_d;
  logic [31:0]          tx_q, tx_d;
  logic [31:0]          rx_q, rx_d;
  logic [31:0]          data_in_q, data_in_d;

  logic [DIV_WIDTH-1:0] div_raw, div_in;
  logic [4:0]           lead_shift;
  logic [5:0]           last_half;
  logic                 start;

  assign div_raw = spi_bitrate[DIV_WIDTH-1:0];
  assign div_in  = (div_raw == '0) ? DivOne : div_raw;
  assign start   = ctrl_wr & spi_ctrl[0];

  // Left-justify the transmit word so the MSB of the selected length sits in bit 31.
  always_comb begin
    lead_shift = 5'd0;
    unique case (spi_ctrl[2:1])
      2'b00:   lead_shift = 5'd24;
      2'b01:   lead_shift = 5'd16;
      default: lead_shift = 5'd0;
    endcase
  end

  always_comb begin
    last_half = 6'd63;
    unique case (len_q)
      2'b00:   last_half = 6'd15;
      2'b01:   last_half = 6'd31;
      default: last_half = 6'd63;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    half_d    = half_q;
    len_d     = len_q;
    cpol_d    = cpol_q;
    hold_d    = hold_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    done_d    = 1'b0;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_in_d = data_in_q;

    unique case (state_q)
      StIdle: begin
        sclk_d = spi_ctrl[3];
        if (start) begin
          state_d = StSetup;
          len_d   = spi_ctrl[2:1];
          cpol_d  = spi_ctrl[3];
          hold_d  = spi_ctrl[4];
          div_d   = div_in;
          cnt_d   = div_in - DivOne;
          tx_d    = spi_data_out << lead_shift;
          rx_d    = '0;
          cs_n_d  = 1'b0;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          // First leading edge: sample MISO as SCLK leaves its idle level.
          state_d = StShift;
          cnt_d   = div_q - DivOne;
          half_d  = 6'd0;
          sclk_d  = ~cpol_q;
          rx_d    = {rx_q[30:0], spi_miso};
        end else begin
          cnt_d = cnt_q - DivOne;
        end
      end
      StShift: begin
        if (cnt_q == '0) begin
          cnt_d = div_q - DivOne;
          if (half_q == last_half) begin
            state_d = StHold;
            sclk_d  = cpol_q;
          end else begin
            half_d = half_q + 6'd1;
            sclk_d = ~sclk_q;
            if (half_q[0]) begin
              rx_d = {rx_q[30:0], spi_miso};
            end else if ((half_q + 6'd1) != last_half) begin
              tx_d = {tx_q[30:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q - DivOne;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          data_in_d = rx_q;
          cs_n_d    = ~hold_q;
          sclk_d    = cpol_q;
        end else begin
          cnt_d = cnt_q - DivOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= DivOne;
      half_q    <= '0;
      len_q     <= '0;
      cpol_q    <= 1'b0;
      hold_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      done_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      half_q    <= half_d;
      len_q     <= len_d;
      cpol_q    <= cpol_d;
      hold_q    <= hold_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      done_q    <= done_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_in_q <= data_in_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign spi_sclk    = sclk_q;
  assign spi_cs_n    = cs_n_q;
  assign spi_mosi    = busy & tx_q[31];
  assign spi_data_in = data_in_q;

  logic unused_bits;
  assign unused_bits = ^{spi_bitrate[31:DIV_WIDTH], spi_ctrl[7:5]};

endmodule

// File: tb/tb_spi_transfer_ctrl.sv
// Directed bench for spi_transfer_ctrl: transfer lengths, CPOL, divider, busy-start,
// back-to-back start, cs_hold and asynchronous reset abort.
module tb_spi_transfer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] spi_bitrate = '0;
  logic [31:0] spi_data_out = '0;
  logic [7:0]  spi_ctrl = '0;
  logic        ctrl_wr = 1'b0;
  logic        spi_miso;
  logic        spi_sclk, spi_mosi, spi_cs_n, busy, done;
  logic [31:0] spi_data_in;

  logic loopback = 1'b1;
  logic miso_tie = 1'b0;
  assign spi_miso = loopback ? spi_mosi : miso_tie;

  always #5 clk = ~clk;

  spi_transfer_ctrl #(.DIV_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_bitrate  (spi_bitrate),
    .spi_data_out (spi_data_out),
    .spi_ctrl     (spi_ctrl),
    .ctrl_wr      (ctrl_wr),
    .spi_miso     (spi_miso),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_cs_n     (spi_cs_n),
    .spi_data_in  (spi_data_in),
    .busy         (busy),
    .done         (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          busy_cyc, done_cnt, lead_gap;
  logic [31:0] mosi_word, data_mid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where busy is first seen low.
  task automatic run_xfer(input logic [31:0] rate, input logic [31:0] data,
                          input logic [7:0] ctrl, input int inject_at);
    int   first_lead;
    logic prev, cpol;
    logic finished;
    cpol = ctrl[3];
    prev = cpol;
    busy_cyc = 0; done_cnt = 0; lead_gap = 0; mosi_word = '0; data_mid = '0;
    first_lead = -1;
    finished = 1'b0;
    spi_bitrate = rate; spi_data_out = data; spi_ctrl = ctrl; ctrl_wr = 1'b1;
    @(negedge clk);
    ctrl_wr = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc == inject_at) begin
        spi_data_out = '0; spi_ctrl = 8'h01; ctrl_wr = 1'b1;
      end else begin
        ctrl_wr = 1'b0;
      end
      if (done) done_cnt++;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      busy_cyc++;
      if (cyc == 3) data_mid = spi_data_in;
      if (spi_sclk != prev && spi_sclk == ~cpol) begin
        mosi_word = {mosi_word[30:0], spi_mosi};
        if (first_lead < 0) first_lead = cyc;
        else if (lead_gap == 0) lead_gap = cyc - first_lead;
      end
      prev = spi_sclk;
      @(negedge clk);
    end
    ctrl_wr = 1'b0;
    check("xfer_end", {31'b0, finished}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    repeat (2) @(negedge clk);
    check("rst_sclk", {31'b0, spi_sclk}, 32'd0);
    check("rst_mosi", {31'b0, spi_mosi}, 32'd0);
    check("rst_cs_n", {31'b0, spi_cs_n}, 32'd1);
    check("rst_data_in", spi_data_in, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Write without start bit must not launch a transfer.
    spi_ctrl = 8'h02; ctrl_wr = 1'b1;
    @(negedge clk);
    ctrl_wr = 1'b0;
    check("nostart_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);

    // 8-bit, D=1, loopback
    loopback = 1'b1;
    run_xfer(32'd1, 32'hA5, 8'h01, -1);
    check("t1_busy", busy_cyc, 32'd18);
    check("t1_mosi", mosi_word, 32'hA5);
    check("t1_done", done_cnt, 32'd1);
    check("t1_data_in", spi_data_in, 32'h0000_00A5);
    check("t1_cs_n", {31'b0, spi_cs_n}, 32'd1);
    @(negedge clk);
    check("t1_done_pulse", {31'b0, done}, 32'd0);

    // 16-bit, D=4, MISO tied high
    loopback = 1'b0; miso_tie = 1'b1;
    run_xfer(32'd4, 32'h1234_5678, 8'h03, -1);
    check("t2_busy", busy_cyc, 32'd136);
    check("t2_sclk_period", lead_gap, 32'd8);
    check("t2_mosi", mosi_word, 32'h5678);
    check("t2_data_in", spi_data_in, 32'h0000_FFFF);
    check("t2_done", done_cnt, 32'd1);

    // 32-bit, D=2, CPOL=1, loopback
    loopback = 1'b1;
    spi_ctrl = 8'h0D;
    repeat (2) @(negedge clk);
    check("t3_sclk_idle_pre", {31'b0, spi_sclk}, 32'd1);
    run_xfer(32'd2, 32'h8765_4321, 8'h0D, -1);
    check("t3_busy", busy_cyc, 32'd132);
    check("t3_data_mid", data_mid, 32'h0000_FFFF);
    check("t3_mosi", mosi_word, 32'h8765_4321);
    check("t3_data_in", spi_data_in, 32'h8765_4321);
    @(negedge clk);
    check("t3_sclk_idle_post", {31'b0, spi_sclk}, 32'd1);

    // Start while busy is ignored; start in the done cycle is accepted
    spi_ctrl = 8'h01;
    @(negedge clk);
    run_xfer(32'd1, 32'h3C, 8'h01, 6);
    check("t4_busy", busy_cyc, 32'd18);
    check("t4_done", done_cnt, 32'd1);
    check("t4_data_in", spi_data_in, 32'h3C);
    check("t4_done_cycle", {31'b0, done}, 32'd1);
    run_xfer(32'd1, 32'hC3, 8'h01, -1);
    check("t4b_busy", busy_cyc, 32'd18);
    check("t4b_data_in", spi_data_in, 32'hC3);
    check("t4b_done", done_cnt, 32'd1);
    @(negedge clk);

    // Divider 0 behaves as 1; cs_hold keeps CS low until a non-hold transfer ends
    run_xfer(32'd0, 32'h5A, 8'h11, -1);
    check("t5_busy", busy_cyc, 32'd18);
    check("t5_data_in", spi_data_in, 32'h5A);
    check("t5_cs_hold_end", {31'b0, spi_cs_n}, 32'd0);
    repeat (3) @(negedge clk);
    check("t5_cs_hold_idle", {31'b0, spi_cs_n}, 32'd0);
    run_xfer(32'd1, 32'h96, 8'h01, -1);
    check("t5b_data_in", spi_data_in, 32'h96);
    check("t5b_cs_release", {31'b0, spi_cs_n}, 32'd1);
    @(negedge clk);

    // Reset in the middle of SHIFT
    spi_bitrate = 32'd1; spi_data_out = 32'hFF; spi_ctrl = 8'h01; ctrl_wr = 1'b1;
    @(negedge clk);
    ctrl_wr = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_busy_before", {31'b0, busy}, 32'd1);
    check("t6_cs_n_before", {31'b0, spi_cs_n}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("t6_cs_n", {31'b0, spi_cs_n}, 32'd1);
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_data_in", spi_data_in, 32'h0);
    check("t6_sclk", {31'b0, spi_sclk}, 32'd0);
    check("t6_mosi", {31'b0, spi_mosi}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("t6_no_done", dcount, 32'd0);
    check("t6_idle_busy", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_transfer_ctrl.md
SPI_TRANSFER_CTRL -- requirements
Module: spi_transfer_ctrl

Interface
REQ-001 Parameter DIV_WIDTH, default 16: width of the SCLK half-period divider taken from spi_bitrate.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; asserted when 0.
REQ-004 spi_bitrate  input  32  SCLK half-period in clk cycles, bits [DIV_WIDTH-1:0] used.
REQ-005 spi_data_out  input  32  transmit word, right-aligned.
REQ-006 spi_ctrl  input  8  [0] start, [2:1] length (00=8, 01=16, 1x=32 bits), [3] CPOL, [4] cs_hold, [7:5] ignored.
REQ-007 ctrl_wr  input  1  one-cycle strobe: spi_ctrl was written this cycle.
REQ-008 spi_miso  input  1  serial data from slave.
REQ-009 spi_sclk  output  1  serial clock.
REQ-010 spi_mosi  output  1  serial data to slave, MSB first.
REQ-011 spi_cs_n  output  1  chip select, active-low.
REQ-012 spi_data_in  output  32  last received word, right-aligned, zero-extended.
REQ-013 busy  output  1  transfer in progress.
REQ-014 done  output  1  one-cycle pulse at transfer end.

Function
REQ-015 States: IDLE, SETUP, SHIFT, HOLD; every state other than IDLE drives busy=1.
REQ-016 Start condition: ctrl_wr=1 and spi_ctrl[0]=1 sampled in IDLE.
- On start, latch spi_data_out, length, CPOL, cs_hold and divider; enter SETUP next cycle.
REQ-017 Divider value D = spi_bitrate[DIV_WIDTH-1:0]; a value of 0 is treated as 1.
REQ-018 Start while busy=1 is ignored; the latched transfer parameters are unchanged.
REQ-019 SETUP lasts D cycles:
- spi_cs_n=0.
- spi_mosi = bit N-1 of the latched data (N = transfer length).
- spi_sclk = CPOL.
REQ-020 SHIFT lasts 2N half-periods of D cycles; spi_sclk toggles at the start of each half-period.
REQ-021 On each leading edge (CPOL to !CPOL), sample spi_miso into the receive shift register LSB; mode CPHA=0 only.
REQ-022 On each trailing edge except the last, advance spi_mosi to the next lower bit.
REQ-023 After the 2N-th half-period, enter HOLD: D cycles, spi_sclk=CPOL, spi_cs_n stays 0.
REQ-024 HOLD exit, in the same cycle:
- return to IDLE; busy=0; done=1.
- spi_data_in = received N bits, zero-extended.
- spi_cs_n=1 unless cs_hold=1; with cs_hold=1, spi_cs_n stays 0 until the next transfer end with cs_hold=0.
REQ-025 Latency: busy is high for exactly (2N+2)*D cycles, starting the cycle after the start strobe.
REQ-026 In IDLE:
- spi_sclk follows spi_ctrl[3] (registered).
- spi_mosi=0.
REQ-027 spi_data_in changes only at transfer end; it holds its value while busy.
REQ-028 The divider counter and bit counter wrap-free: reload at each half-period; bit counter is sized for 64 half-periods.
REQ-029 A new start in the cycle done=1 (state IDLE) is accepted.

Reset
REQ-030 While rst=0, regardless of clk:
- state=IDLE; spi_sclk=0, spi_mosi=0, spi_cs_n=1.
- spi_data_in=0, busy=0, done=0, cs_hold latch=0.
REQ-031 Reset mid-transfer aborts immediately: spi_cs_n=1 and no done pulse; the partial received data is discarded.

Verification
REQ-032 8-bit transfer:
- Stimulus: D=1, data_out=0xA5, ctrl=0x01, MISO loopback.
- Response: busy high 18 cycles, MOSI bits 1,0,1,0,0,1,0,1, done pulse, data_in=0x000000A5.
REQ-033 16-bit transfer:
- Stimulus: D=4, data_out=0x12345678, ctrl=0x03, MISO tied 1.
- Response: busy 136 cycles, SCLK period 8 cycles, data_in=0x0000FFFF, MOSI carries 0x5678.
REQ-034 32-bit transfer, CPOL=1:
- Stimulus: D=2, data_out=0x87654321, ctrl=0x0D, loopback.
- Response: SCLK idles 1, busy 132 cycles, data_in=0x87654321.
REQ-035 Start during busy:
- Stimulus: second ctrl_wr with ctrl=0x01 mid-transfer.
- Response: ignored, single done pulse; a start in the done cycle starts a second transfer.
REQ-036 Divider 0 and cs_hold:
- Stimulus: spi_bitrate=0 with ctrl=0x11.
- Response: behaves as D=1; spi_cs_n remains 0 after done until a following transfer with cs_hold=0 ends.
REQ-037 Reset mid-SHIFT: rst=0 at cycle 5 of a transfer -> spi_cs_n=1, busy=0, spi_data_in=0, no done.
